// File: rtl/unidade_controle_genius_if.sv
// Control/status bundle between the genius control unit and the game datapath.
// The slave side is the control unit; the master side is the datapath/top level.
interface unidade_controle_genius_if #(
  parameter int ESTADO_W = 5
);
  // inputs to the control unit
  logic jogar;
  logic modo;
  logic timeout_hab;
  logic jogada;
  logic igual;
  logic enderecoIgualLimite;
  logic fimL;
  logic fimT;
  logic fimTM;
  // enables and status driven by the control unit
  logic zeraE;
  logic contaE;
  logic zeraL;
  logic contaL;
  logic zeraR;
  logic registraR;
  logic escreveM;
  logic zeraT;
  logic contaT;
  logic zeraTM;
  logic contaTM;
  logic leds_en;
  logic pronto;
  logic ganhou;
  logic perdeu;
  logic timeout;
  logic [ESTADO_W-1:0] db_estado;

  modport master (
    output jogar, modo, timeout_hab, jogada, igual, enderecoIgualLimite, fimL, fimT, fimTM,
    input  zeraE, contaE, zeraL, contaL, zeraR, registraR, escreveM, zeraT, contaT,
           zeraTM, contaTM, leds_en, pronto, ganhou, perdeu, timeout, db_estado
  );

  modport slave (
    input  jogar, modo, timeout_hab, jogada, igual, enderecoIgualLimite, fimL, fimT, fimTM,
    output zeraE, contaE, zeraL, contaL, zeraR, registraR, escreveM, zeraT, contaT,
           zeraTM, contaTM, leds_en, pronto, ganhou, perdeu, timeout, db_estado
  );
endinterface

// File: rtl/unidade_controle_genius.sv
// Moore control unit for the memory game: demonstration, player turn,
// extra-play write-back, round advance and win/lose/timeout endings.
// Outputs are registered from the next-state decode so they change together
// with db_estado and never depend combinationally on inputs.
module unidade_controle_genius #(
  parameter int ESTADO_W = 5
) (
  input logic                      clock,
  input logic                      reset,
  unidade_controle_genius_if.slave bus
);

  typedef enum logic [4:0] {
    S_INICIAL       = 5'h00,
    S_PREPARACAO    = 5'h01,
    S_INICIA_RODADA = 5'h02,
    S_MOSTRA_LED    = 5'h03,
    S_APAGA_LED     = 5'h04,
    S_PROXIMO_LED   = 5'h05,
    S_FIM_EXIBICAO  = 5'h06,
    S_ESPERA_JOGADA = 5'h07,
    S_REGISTRA      = 5'h08,
    S_COMPARA       = 5'h09,
    S_PROXIMA_JOG   = 5'h0A,
    S_ESPERA_ADIC   = 5'h0B,
    S_REGISTRA_ADIC = 5'h0C,
    S_GRAVA         = 5'h0D,
    S_PROXIMA_ROD   = 5'h0E,
    S_FINAL_ACERTOU = 5'h0F,
    S_FINAL_ERROU   = 5'h10,
    S_FINAL_TIMEOUT = 5'h11,
    S_APAGA_INICIO  = 5'h12
  } estado_t;

  // packed output vector bit masks
  localparam logic [15:0] O_ZERAE    = 16'h8000;
  localparam logic [15:0] O_CONTAE   = 16'h4000;
  localparam logic [15:0] O_ZERAL    = 16'h2000;
  localparam logic [15:0] O_CONTAL   = 16'h1000;
  localparam logic [15:0] O_ZERAR    = 16'h0800;
  localparam logic [15:0] O_REGISTRA = 16'h0400;
  localparam logic [15:0] O_ESCREVEM = 16'h0200;
  localparam logic [15:0] O_ZERAT    = 16'h0100;
  localparam logic [15:0] O_CONTAT   = 16'h0080;
  localparam logic [15:0] O_ZERATM   = 16'h0040;
  localparam logic [15:0] O_CONTATM  = 16'h0020;
  localparam logic [15:0] O_LEDS     = 16'h0010;
  localparam logic [15:0] O_PRONTO   = 16'h0008;
  localparam logic [15:0] O_GANHOU   = 16'h0004;
  localparam logic [15:0] O_PERDEU   = 16'h0002;
  localparam logic [15:0] O_TIMEOUT  = 16'h0001;

  estado_t     estado_q, estado_d;
  logic        modo_flag_q, modo_flag_d;
  logic        timeout_flag_q, timeout_flag_d;
  logic [15:0] saidas_q, saidas_d;

  // next-state logic; configuration flags are captured only in preparacao
  always_comb begin
    estado_d       = estado_q;
    modo_flag_d    = modo_flag_q;
    timeout_flag_d = timeout_flag_q;
    case (estado_q)
      S_INICIAL: begin
        if (bus.jogar) estado_d = S_PREPARACAO;
        else           estado_d = S_INICIAL;
      end
      S_PREPARACAO: begin
        modo_flag_d    = bus.modo;
        timeout_flag_d = bus.timeout_hab;
        if (bus.modo) estado_d = S_INICIA_RODADA;
        else          estado_d = S_ESPERA_JOGADA;
      end
      S_INICIA_RODADA: estado_d = S_MOSTRA_LED;
      S_MOSTRA_LED: begin
        if (bus.fimTM) estado_d = S_APAGA_INICIO;
        else           estado_d = S_MOSTRA_LED;
      end
      S_APAGA_INICIO: estado_d = S_APAGA_LED;
      S_APAGA_LED: begin
        if (!bus.fimTM)                   estado_d = S_APAGA_LED;
        else if (bus.enderecoIgualLimite) estado_d = S_FIM_EXIBICAO;
        else                              estado_d = S_PROXIMO_LED;
      end
      S_PROXIMO_LED:  estado_d = S_MOSTRA_LED;
      S_FIM_EXIBICAO: estado_d = S_ESPERA_JOGADA;
      S_ESPERA_JOGADA: begin
        if (bus.jogada)                        estado_d = S_REGISTRA;
        else if (bus.fimT && timeout_flag_q)   estado_d = S_FINAL_TIMEOUT;
        else                                   estado_d = S_ESPERA_JOGADA;
      end
      S_REGISTRA: estado_d = S_COMPARA;
      S_COMPARA: begin
        if (!bus.igual)                   estado_d = S_FINAL_ERROU;
        else if (bus.enderecoIgualLimite) estado_d = S_ESPERA_ADIC;
        else                              estado_d = S_PROXIMA_JOG;
      end
      S_PROXIMA_JOG: estado_d = S_ESPERA_JOGADA;
      S_ESPERA_ADIC: begin
        if (bus.jogada)                        estado_d = S_REGISTRA_ADIC;
        else if (bus.fimT && timeout_flag_q)   estado_d = S_FINAL_TIMEOUT;
        else                                   estado_d = S_ESPERA_ADIC;
      end
      S_REGISTRA_ADIC: estado_d = S_GRAVA;
      S_GRAVA: begin
        if (bus.fimL) estado_d = S_FINAL_ACERTOU;
        else          estado_d = S_PROXIMA_ROD;
      end
      S_PROXIMA_ROD: begin
        if (modo_flag_q) estado_d = S_INICIA_RODADA;
        else             estado_d = S_ESPERA_JOGADA;
      end
      S_FINAL_ACERTOU, S_FINAL_ERROU, S_FINAL_TIMEOUT: begin
        if (bus.jogar) estado_d = S_PREPARACAO;
        else           estado_d = estado_q;
      end
      default: estado_d = S_INICIAL;
    endcase
  end

  // Moore output decode of the state being entered, registered below
  always_comb begin
    saidas_d = 16'h0000;
    case (estado_d)
      S_PREPARACAO:    saidas_d = O_ZERAE | O_ZERAL | O_ZERAR | O_ZERAT | O_ZERATM;
      S_INICIA_RODADA: saidas_d = O_ZERAE | O_ZERATM;
      S_MOSTRA_LED:    saidas_d = O_LEDS | O_CONTATM;
      S_APAGA_INICIO:  saidas_d = O_ZERATM;
      S_APAGA_LED:     saidas_d = O_CONTATM;
      S_PROXIMO_LED:   saidas_d = O_CONTAE | O_ZERATM;
      S_FIM_EXIBICAO:  saidas_d = O_ZERAE | O_ZERAT;
      S_ESPERA_JOGADA: saidas_d = timeout_flag_d ? O_CONTAT : 16'h0000;
      S_REGISTRA:      saidas_d = O_REGISTRA | O_ZERAT;
      S_COMPARA:       saidas_d = 16'h0000;
      S_PROXIMA_JOG:   saidas_d = O_CONTAE;
      S_ESPERA_ADIC:   saidas_d = timeout_flag_d ? O_CONTAT : 16'h0000;
      S_REGISTRA_ADIC: saidas_d = O_REGISTRA | O_ZERAT;
      S_GRAVA:         saidas_d = O_ESCREVEM;
      S_PROXIMA_ROD:   saidas_d = O_CONTAL | O_ZERAE | O_ZERAT;
      S_FINAL_ACERTOU: saidas_d = O_PRONTO | O_GANHOU;
      S_FINAL_ERROU:   saidas_d = O_PRONTO | O_PERDEU;
      S_FINAL_TIMEOUT: saidas_d = O_PRONTO | O_PERDEU | O_TIMEOUT;
      default:         saidas_d = 16'h0000;
    endcase
  end

  // state, flag and output registers with synchronous reset
  always_ff @(posedge clock) begin
    if (reset) begin
      estado_q       <= S_INICIAL;
      modo_flag_q    <= 1'b0;
      timeout_flag_q <= 1'b0;
      saidas_q       <= 16'h0000;
    end else begin
      estado_q       <= estado_d;
      modo_flag_q    <= modo_flag_d;
      timeout_flag_q <= timeout_flag_d;
      saidas_q       <= saidas_d;
    end
  end

  assign bus.zeraE     = saidas_q[15];
  assign bus.contaE    = saidas_q[14];
  assign bus.zeraL     = saidas_q[13];
  assign bus.contaL    = saidas_q[12];
  assign bus.zeraR     = saidas_q[11];
  assign bus.registraR = saidas_q[10];
  assign bus.escreveM  = saidas_q[9];
  assign bus.zeraT     = saidas_q[8];
  assign bus.contaT    = saidas_q[7];
  assign bus.zeraTM    = saidas_q[6];
  assign bus.contaTM   = saidas_q[5];
  assign bus.leds_en   = saidas_q[4];
  assign bus.pronto    = saidas_q[3];
  assign bus.ganhou    = saidas_q[2];
  assign bus.perdeu    = saidas_q[1];
  assign bus.timeout   = saidas_q[0];
  assign bus.db_estado = ESTADO_W'(estado_q);

endmodule

// File: doc/unidade_controle_genius.md
Name: unidade_controle_genius

Overview:
- Moore FSM that sequences the memory-game datapath: initial demonstration, player-turn comparison, extra-play write-back, round advance and the win/lose/timeout endings.
- Drives the datapath's counter, register, memory, timer and LED enables.
- Consumes the datapath's status flags.
- Sits between the top-level game circuit's inputs (jogar, configuracao) and the datapath. It replaces the hand-wired control of the previous experiment.

Parameters:
- ESTADO_W, 5, width of db_estado (state code, feeds the 7-seg decoder via zero-extension).

Ports:
- clock  in  1  system clock (1 kHz in board build).
- reset  in  1  synchronous, active-high; forces state inicial.
- jogar  in  1  start/restart request (level).
- modo  in  1  configuracao[0]; 1 = demonstration before each round.
- timeout_hab  in  1  configuracao[1]; 1 = timeout enabled.
- jogada  in  1  one-cycle pulse per button press (edge detector in datapath).
- igual  in  1  registered play equals memory word.
- enderecoIgualLimite  in  1  address counter == round counter.
- fimL  in  1  round counter at last round.
- fimT  in  1  play timeout timer expired.
- fimTM  in  1  LED display timer expired.
- zeraE, contaE  out  1  address counter clear/increment.
- zeraL, contaL  out  1  round counter clear/increment.
- zeraR, registraR  out  1  play register clear/load.
- escreveM  out  1  memory write at current address.
- zeraT, contaT  out  1  timeout timer clear/count.
- zeraTM, contaTM  out  1  display timer clear/count.
- leds_en  out  1  LEDs show memory word.
- pronto, ganhou, perdeu, timeout  out  1  game status.
- db_estado  out  ESTADO_W  current state code.

Behaviour:
- Structure: state register updated on posedge clock. Outputs decoded from state only (Moore, no input-dependent outputs). Reset has priority over every transition; mid-game reset returns to inicial on that edge.
- Reset values: every output 0; db_estado=0.
- modo and timeout_hab are sampled into internal flags in preparacao only. Later changes are ignored until the next start.
- State codes, asserted outputs, and transitions:
  - 0x00 inicial: none. jogar -> preparacao.
  - 0x01 preparacao: zeraE, zeraL, zeraR, zeraT, zeraTM. modo_flag ? inicia_rodada : espera_jogada.
  - 0x02 inicia_rodada: zeraE, zeraTM. -> mostra_led.
  - 0x03 mostra_led: leds_en, contaTM. fimTM -> apaga_led.
  - 0x04 apaga_led: contaTM after one-cycle zeraTM on entry (handled in proximo_led/inicia path). fimTM -> (enderecoIgualLimite ? fim_exibicao : proximo_led).
  - 0x05 proximo_led: contaE, zeraTM. -> mostra_led.
  - 0x06 fim_exibicao: zeraE, zeraT. -> espera_jogada.
  - 0x07 espera_jogada: contaT iff timeout_flag. Priority: jogada -> registra; else fimT & timeout_flag -> final_timeout.
  - 0x08 registra: registraR, zeraT. -> compara.
  - 0x09 compara: !igual -> final_errou; igual & enderecoIgualLimite -> espera_adicional; else proxima_jogada.
  - 0x0A proxima_jogada: contaE. -> espera_jogada.
  - 0x0B espera_adicional: contaT iff timeout_flag. jogada -> registra_adicional; else fimT & timeout_flag -> final_timeout.
  - 0x0C registra_adicional: registraR, zeraT. -> grava.
  - 0x0D grava: escreveM (address = limite+1 already selected by datapath). fimL -> final_acertou; else proxima_rodada.
  - 0x0E proxima_rodada: contaL, zeraE, zeraT. modo_flag ? inicia_rodada : espera_jogada.
  - 0x0F final_acertou: pronto, ganhou.
  - 0x10 final_errou: pronto, perdeu.
  - 0x11 final_timeout: pronto, perdeu, timeout.
  - Finals hold until jogar -> preparacao.
- apaga_led entry: mostra_led exit requires zeraTM for one cycle. mostra_led->apaga_led therefore passes through a 1-cycle state 0x12 apaga_inicio (zeraTM) -> apaga_led.
- Latency:
  - jogada pulse to registraR: 1 cycle.
  - To igual decision: 2 cycles.
  - fimT to pronto: 1 cycle.
- Simultaneous jogada & fimT: jogada wins.
- timeout_flag=0: contaT never asserted, fimT ignored; game can wait indefinitely.
- Unused codes 0x13-0x1F -> inicial next cycle, outputs 0.
- jogada outside espera states is ignored.
- ganhou/perdeu/timeout are mutually exclusive; pronto=1 only in finals.

Test Plan:
- reset 2 cycles, jogar=0 -> db_estado=0x00, all outputs 0 for 10 cycles.
- modo=1, timeout_hab=1, jogar pulse -> 0x01 then 0x02. leds_en high until fimTM. Then jogada with igual=1, enderecoIgualLimite=1 -> reaches 0x0B. Hold fimT=1 -> 0x11, pronto=perdeu=timeout=1, ganhou=0.
- modo=0, wrong play (igual=0) in round 1 -> registra(0x08), compara(0x09), final_errou(0x10). perdeu=1, timeout=0.
- Full game with igual=1 always, fimL asserted on round N -> escreveM pulses exactly once per round, contaL N-1 times, ends 0x0F ganhou=1.
- timeout_hab=0, fimT=1 held 500 cycles in espera_jogada -> state stays 0x07, contaT=0.
- reset asserted in 0x03 and again in 0x0F -> next edge db_estado=0x00, leds_en/pronto drop to 0. jogar in final -> 0x01, flags re-sampled.
